// File: rtl/count_seq_monitor_pkg.sv
// Shared types and default sizes for the count sequence monitor.
// Optional feature macro: COUNT_SEQ_MONITOR_HOLD_OK_EN (hold samples are neutral).
package count_seq_monitor_pkg;

    // Monitor FSM encoding, fixed so status logic can decode it directly.
    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } mon_state_e;

    localparam int unsigned DEF_WIDTH      = 4;
    localparam int unsigned DEF_SYNC_LEN   = 2;
    localparam int unsigned DEF_ERR_CNT_W  = 8;
    localparam int unsigned DEF_WRAP_CNT_W = 8;

    // The streak counter is sized for the largest supported SYNC_LEN (15).
    localparam int unsigned STREAK_W       = 4;

endpackage : count_seq_monitor_pkg

// File: rtl/count_seq_monitor_satcnt.sv
// Statistics counter for the count sequence monitor: increment, synchronous
// clear and a choice between saturating at all-ones or wrapping to zero.
module count_mon_satcnt #(
    parameter int unsigned CNT_W    = 8,
    parameter bit          SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, then increment with saturate or wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            if (SATURATE && (cnt_q == '1)) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule : count_mon_satcnt

// File: rtl/count_seq_monitor.sv
// Count sequence monitor: locks onto a +1 modulo-2^WIDTH counter sequence,
// flags breaks in the sequence and reports wrap-arounds, with error and wrap
// statistics. Asynchronous active-low reset on port `reset`.
// Optional feature macro: COUNT_SEQ_MONITOR_HOLD_OK_EN -- when defined, a
// repeated value (hold) is neutral in SYNC and LOCKED instead of a mismatch.
module count_seq_monitor
    import count_seq_monitor_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned SYNC_LEN   = DEF_SYNC_LEN,
    parameter int unsigned ERR_CNT_W  = DEF_ERR_CNT_W,
    parameter int unsigned WRAP_CNT_W = DEF_WRAP_CNT_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      count_in,
    input  logic                  valid_in,
    input  logic                  clear,
    output logic                  locked,
    output logic                  error_pulse,
    output logic                  wrap_pulse,
    output logic [ERR_CNT_W-1:0]  err_count,
    output logic [WRAP_CNT_W-1:0] wrap_count
);

`ifdef COUNT_SEQ_MONITOR_HOLD_OK_EN
    localparam bit HOLD_OK = 1'b1;
`else
    localparam bit HOLD_OK = 1'b0;
`endif

    localparam logic [STREAK_W-1:0] SYNC_TGT = STREAK_W'(SYNC_LEN);

    mon_state_e          state_q, state_d;
    logic [WIDTH-1:0]    prev_q, prev_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                locked_q, locked_d;
    logic                error_pulse_q, error_pulse_d;
    logic                wrap_pulse_q, wrap_pulse_d;

    logic                err_inc;
    logic                wrap_inc;
    logic                is_match;
    logic                is_hold;
    logic                hold_neutral;
    logic [STREAK_W-1:0] streak_inc;

    // Sample classification against the previously captured value.
    always_comb begin
        is_match     = (count_in == (prev_q + WIDTH'(1)));
        is_hold      = (count_in == prev_q);
        hold_neutral = HOLD_OK && is_hold;
        streak_inc   = streak_q + STREAK_W'(1);
    end

    // Next-state, statistics strobes and registered-output next values.
    always_comb begin
        state_d       = state_q;
        prev_d        = prev_q;
        streak_d      = streak_q;
        err_inc       = 1'b0;
        wrap_inc      = 1'b0;
        error_pulse_d = 1'b0;
        wrap_pulse_d  = 1'b0;

        if (clear) begin
            // The simultaneous sample is dropped, so prev is left as is.
            state_d  = UNSYNC;
            streak_d = '0;
        end else if (valid_in) begin
            prev_d = count_in;
            unique case (state_q)
                UNSYNC: begin
                    streak_d = '0;
                    state_d  = SYNC;
                end
                SYNC: begin
                    if (hold_neutral) begin
                        state_d = SYNC;
                    end else if (is_match) begin
                        streak_d = streak_inc;
                        if (streak_inc == SYNC_TGT) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        streak_d = '0;
                    end
                end
                LOCKED: begin
                    if (hold_neutral) begin
                        state_d = LOCKED;
                    end else if (is_match) begin
                        if (prev_q == '1) begin
                            wrap_pulse_d = 1'b1;
                            wrap_inc     = 1'b1;
                        end
                    end else begin
                        error_pulse_d = 1'b1;
                        err_inc       = 1'b1;
                        streak_d      = '0;
                        state_d       = SYNC;
                    end
                end
                default: begin
                    state_d  = UNSYNC;
                    streak_d = '0;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    // State, history and registered status outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= UNSYNC;
            prev_q        <= '0;
            streak_q      <= '0;
            locked_q      <= 1'b0;
            error_pulse_q <= 1'b0;
            wrap_pulse_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_q        <= prev_d;
            streak_q      <= streak_d;
            locked_q      <= locked_d;
            error_pulse_q <= error_pulse_d;
            wrap_pulse_q  <= wrap_pulse_d;
        end
    end

    count_mon_satcnt #(
        .CNT_W    (ERR_CNT_W),
        .SATURATE (1'b1)
    ) u_err_cnt (
        .clk   (clock),
        .rst_n (reset),
        .clr   (clear),
        .inc   (err_inc),
        .count (err_count)
    );

    count_mon_satcnt #(
        .CNT_W    (WRAP_CNT_W),
        .SATURATE (1'b0)
    ) u_wrap_cnt (
        .clk   (clock),
        .rst_n (reset),
        .clr   (clear),
        .inc   (wrap_inc),
        .count (wrap_count)
    );

    assign locked      = locked_q;
    assign error_pulse = error_pulse_q;
    assign wrap_pulse  = wrap_pulse_q;

endmodule : count_seq_monitor
